// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction fetch stage feeding the RV64I decode stage. Owns the fetch PC,
// keeps at most one instruction-memory request outstanding, and buffers
// returned words (with the PC they were fetched from) in a small circular
// FIFO. A redirect from execute flushes the FIFO and discards any response
// that is still in flight.
//
// Parameters:
//   RESET_PC   fetch PC loaded on reset
//   BUF_DEPTH  instruction FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk              clock
//   rst              synchronous, active-high reset
//   redirect_valid   execute requests a PC change this cycle
//   redirect_pc      new fetch PC (bits [1:0] ignored)
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts the request
//   imem_req_addr    fetch address (always the current fetch PC)
//   imem_resp_valid  response valid; responses return in order
//   imem_resp_data   fetched instruction word
//   inst_valid       FIFO head valid toward decode
//   inst_ready       decode consumes the head
//   inst             head instruction, NOP (addi x0,x0,0) when empty
//   inst_addr        head PC, 0 when empty
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. The producer holds valid and payload stable until the transfer; the
// consumer may drive ready independently of valid.
//
// Build option: define FETCH_BYPASS_EN to let a response reach decode in the
// same cycle when the FIFO is empty (zero-latency bypass). Without it every
// instruction passes through the FIFO with a fixed one-cycle latency.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [63:0] inst_addr
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
   localparam logic [31:0]   NOP     = 32'h0000_0013;

   // IDLE: nothing outstanding. WAIT: response pending and kept.
   // DROP: response pending but a redirect has made it stale.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   logic [1:0]    state;
   logic [63:0]   fetch_pc;
   logic [63:0]   req_pc;
   logic [CW-1:0] count;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   buf_data [BUF_DEPTH];
   logic [63:0]   buf_pc   [BUF_DEPTH];

   logic fifo_empty;
   logic req_fire;
   logic resp_keep;
   logic bypass_hit;
   logic push;
   logic pop;

   // The low bits of a redirect target are always forced to zero.
   logic redirect_pc_unused;
   assign redirect_pc_unused = ^redirect_pc[1:0];

   assign fifo_empty = (count == '0);

   // Never request on a redirect cycle: the address would already be stale.
   assign imem_req_valid = (state == ST_IDLE) && (count < DEPTH_C) &&
                           !redirect_valid && !rst;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response is only worth keeping in WAIT and when no redirect kills it.
   assign resp_keep = imem_resp_valid && (state == ST_WAIT) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
   assign bypass_hit = fifo_empty && resp_keep;
`else
   assign bypass_hit = 1'b0;
`endif

   assign inst_valid = !fifo_empty || bypass_hit;

   always_comb begin
      inst      = NOP;
      inst_addr = '0;
      if (!fifo_empty) begin
         inst      = buf_data[rd_ptr];
         inst_addr = buf_pc[rd_ptr];
      end else if (bypass_hit) begin
         inst      = imem_resp_data;
         inst_addr = req_pc;
      end
   end

   // A bypassed word that decode takes immediately never enters the FIFO.
   assign pop  = !fifo_empty && inst_ready && !redirect_valid;
   assign push = resp_keep && !(bypass_hit && inst_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[63:2], 2'b00};
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         // A response landing on the redirect cycle closes the transaction;
         // otherwise a pending one must be swallowed when it arrives.
         if (state != ST_IDLE) begin
            state <= imem_resp_valid ? ST_IDLE : ST_DROP;
         end
      end else begin
         if (req_fire) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 64'd4;
         end

         // A response seen in IDLE has no owner and is ignored.
         case (state)
            ST_IDLE: if (req_fire)        state <= ST_WAIT;
            ST_WAIT: if (imem_resp_valid) state <= ST_IDLE;
            ST_DROP: if (imem_resp_valid) state <= ST_IDLE;
            default:                      state <= ST_IDLE;
         endcase

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[wr_ptr] <= imem_resp_data;
         buf_pc[wr_ptr]   <= req_pc;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Self-checking bench for if_fetch_stage. A memory model answers each
// accepted request after a configurable latency. A reference model of the
// fetch state, fetch PC and FIFO contents (the expected queue exp_q) is
// stepped once per cycle; expected {pc, word} entries are pushed when a kept
// response is driven and popped when decode consumes the head.
// Build with +define+FETCH_BYPASS_EN to check the bypass variant.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam int M_IDLE = 0;
   localparam int M_WAIT = 1;
   localparam int M_DROP = 2;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_addr;

   // scoreboard / model state
   logic [95:0] exp_q[$];
   int          n_checks;
   int          n_err;
   int          st;
   logic [63:0] model_pc;
   logic [63:0] model_req_pc;
   int          pop_cnt;
   string       phase;

   // memory model state
   bit          mem_pend;
   logic [63:0] mem_addr;
   int          mem_wait;
   int          mem_lat;     // 0 = random 1..3 cycles
   bit          ovr_en;
   logic [31:0] ovr_data;

   if_fetch_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_addr       (inst_addr)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return {a[15:0], 16'h1013} ^ 32'h0f0f_0000;
   endfunction

   // Reference model: compare outputs for this cycle, then advance.
   task automatic model_cycle();
      int          qn;
      bit          exp_rv;
      bit          byp;
      bit          exp_iv;
      bit          fire;
      logic [95:0] head;
      qn     = exp_q.size();
      exp_rv = (st == M_IDLE) && (qn < DEPTH) && !redirect_valid && !rst;
      byp    = BYP && (qn == 0) && (st == M_WAIT) && imem_resp_valid && !redirect_valid;
      exp_iv = (qn != 0) || byp;
      if (qn != 0)  head = exp_q[0];
      else if (byp) head = {model_req_pc, imem_resp_data};
      else          head = {64'h0, NOP};
      if (!rst) begin
         check({phase, ":req_valid"},  96'(imem_req_valid), 96'(exp_rv));
         check({phase, ":req_addr"},   96'(imem_req_addr),  96'(model_pc));
         check({phase, ":inst_valid"}, 96'(inst_valid),     96'(exp_iv));
         check({phase, ":head"},       {inst_addr, inst},   head);
      end
      fire = exp_rv && imem_req_ready;
      if (rst) begin
         st       = M_IDLE;
         model_pc = RESET_PC;
         exp_q.delete();
      end else if (redirect_valid) begin
         exp_q.delete();
         model_pc = {redirect_pc[63:2], 2'b00};
         if (st != M_IDLE) st = imem_resp_valid ? M_IDLE : M_DROP;
      end else begin
         if (exp_iv && inst_ready) begin
            pop_cnt++;
            if (!byp) void'(exp_q.pop_front());
         end
         case (st)
            M_IDLE: if (fire) begin
               model_req_pc = model_pc;
               model_pc     = model_pc + 64'd4;
               st           = M_WAIT;
            end
            M_WAIT: if (imem_resp_valid) begin
               if (!(byp && inst_ready)) exp_q.push_back({model_req_pc, imem_resp_data});
               st = M_IDLE;
            end
            M_DROP: if (imem_resp_valid) st = M_IDLE;
            default: st = M_IDLE;
         endcase
      end
   endtask

   // ---------------- driver ----------------
   task automatic tick();
      @(negedge clk);
      model_cycle();
      if (imem_resp_valid) mem_pend = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
         mem_pend = 1'b1;
         mem_addr = imem_req_addr;
         mem_wait = (mem_lat == 0) ? int'($urandom_range(2, 0)) : mem_lat - 1;
      end
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (mem_pend) begin
         if (mem_wait == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ovr_en ? ovr_data : mem_word(mem_addr);
            ovr_en          = 1'b0;
         end else begin
            mem_wait--;
         end
      end
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      imem_req_ready  = 1'b0;
      inst_ready      = 1'b0;
      mem_pend        = 1'b0;
      ovr_en          = 1'b0;
      imem_resp_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0; n_err = 0; pop_cnt = 0;
      st = M_IDLE; model_pc = RESET_PC; model_req_pc = '0;
      mem_lat = 1; mem_wait = 0; mem_addr = '0;
      imem_resp_data = '0; ovr_data = '0;
      phase = "reset";
      do_reset();
      settle();
      check("reset:inst_valid", 96'(inst_valid), 96'(0));
      check("reset:head", {inst_addr, inst}, {64'h0, NOP});
      check("reset:req_addr", 96'(imem_req_addr), 96'(RESET_PC));
      tick();

      // 1: streaming with one-cycle memory and ready decode
      phase = "t1";
      do_reset();
      imem_req_ready = 1'b1; inst_ready = 1'b1; mem_lat = 1; pop_cnt = 0;
      for (int i = 0; i < 40 && pop_cnt < 3; i++) tick();
      check("t1:pops", 96'(pop_cnt >= 3), 96'(1));

      // 2: back-pressure fills the FIFO and stops requests
      phase = "t2";
      do_reset();
      imem_req_ready = 1'b1; inst_ready = 1'b0; mem_lat = 1;
      for (int i = 0; i < 20 && exp_q.size() < 2; i++) tick();
      check("t2:full", 96'(exp_q.size()), 96'(2));
      tick(); tick();
      settle();
      check("t2:stall", 96'(imem_req_valid), 96'(0));
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      settle();
      check("t2:req_valid", 96'(imem_req_valid), 96'(1));
      check("t2:next_addr", 96'(imem_req_addr), 96'(64'h8000_0008));
      check("t2:head", {inst_addr, inst}, {64'h8000_0004, mem_word(64'h8000_0004)});
      tick();

      // 3: redirect while waiting; the late response must vanish
      phase = "t3";
      do_reset();
      imem_req_ready = 1'b1; inst_ready = 1'b1; mem_lat = 3;
      tick();
      ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_1002;
      tick();
      redirect_valid = 1'b0;
      settle();
      check("t3:flushed", 96'(inst_valid), 96'(0));
      check("t3:drop_noreq", 96'(imem_req_valid), 96'(0));
      tick(); tick();
      settle();
      check("t3:req_valid", 96'(imem_req_valid), 96'(1));
      check("t3:req_addr", 96'(imem_req_addr), 96'(64'h8000_1000));
      mem_lat = 1; pop_cnt = 0;
      for (int i = 0; i < 20 && pop_cnt < 2; i++) tick();
      check("t3:resume", 96'(pop_cnt >= 2), 96'(1));

      // 4: redirect colliding with a response and a pop
      phase = "t4";
      do_reset();
      imem_req_ready = 1'b1; inst_ready = 1'b0; mem_lat = 1;
      for (int i = 0; i < 20 && !(imem_resp_valid && exp_q.size() == 1 && st == M_WAIT); i++) tick();
      check("t4:setup", 96'(imem_resp_valid && exp_q.size() == 1 && st == M_WAIT), 96'(1));
      inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
      settle();
      check("t4:noreq", 96'(imem_req_valid), 96'(0));
      tick();
      redirect_valid = 1'b0;
      settle();
      check("t4:empty", 96'(inst_valid), 96'(0));
      check("t4:req_valid", 96'(imem_req_valid), 96'(1));
      check("t4:req_addr", 96'(imem_req_addr), 96'(64'h8000_2000));
      tick(); tick(); tick();

      // 5: reset pulse mid-transaction, stray response afterwards
      phase = "t5";
      do_reset();
      imem_req_ready = 1'b1; inst_ready = 1'b0; mem_lat = 2;
      for (int i = 0; i < 20 && !(st == M_WAIT && !imem_resp_valid && exp_q.size() == 1); i++) tick();
      check("t5:setup", 96'(st == M_WAIT && exp_q.size() == 1), 96'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      check("t5:stray", 96'(imem_resp_valid), 96'(1));
      check("t5:inst_valid", 96'(inst_valid), 96'(0));
      check("t5:head", {inst_addr, inst}, {64'h0, NOP});
      check("t5:req_addr", 96'(imem_req_addr), 96'(RESET_PC));
      inst_ready = 1'b1; pop_cnt = 0;
      for (int i = 0; i < 30 && pop_cnt < 2; i++) tick();
      check("t5:restart", 96'(pop_cnt >= 2), 96'(1));

      // 6: empty FIFO response (zero latency with bypass, one cycle without)
      phase = "t6";
      do_reset();
      imem_req_ready = 1'b1; inst_ready = 1'b1; mem_lat = 1;
      ovr_en = 1'b1; ovr_data = 32'h00A0_0093;
      tick();
      settle();
      check("t6:same_valid", 96'(inst_valid), 96'(BYP));
      check("t6:same_head", {inst_addr, inst},
            BYP ? {64'h8000_0000, 32'h00A0_0093} : {64'h0, NOP});
      tick();
      settle();
      check("t6:next_valid", 96'(inst_valid), 96'(!BYP));
      check("t6:next_head", {inst_addr, inst},
            BYP ? {64'h0, NOP} : {64'h8000_0000, 32'h00A0_0093});
      tick();

      // random traffic with back-pressure, variable latency and redirects
      phase = "rand";
      do_reset();
      mem_lat = 0;
      for (int i = 0; i < 400; i++) begin
         imem_req_ready = ($urandom_range(3, 0) != 0);
         inst_ready     = ($urandom_range(1, 0) != 0);
         redirect_valid = ($urandom_range(15, 0) == 0);
         redirect_pc    = {$urandom, $urandom};
         tick();
      end
      redirect_valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
